fft_frame_loader: RTL and testbench



---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_frame_loader_if.sv | 29 ++
 rtl/fft_frame_bank.sv | 39 +++
 rtl/fft_frame_loader.sv | 147 ++++++++++++++
 tb/tb_fft_frame_loader.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: frame geometry, complex sample type and index bit-reversal for the FFT front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_pkg;

  localparam int FFT_N  = 8;
  localparam int FFT_W  = 16;
  localparam int FFT_LN = $clog2(FFT_N);

  // One complex sample; both parts are raw two's complement bit patterns.
  typedef struct packed {
    logic [FFT_W-1:0] re;
    logic [FFT_W-1:0] im;
  } cplx_t;

  // Reverse the FFT_LN-bit sample index (slot k -> slot bitrev(k)).
  function automatic logic [FFT_LN-1:0] bitrev(input logic [FFT_LN-1:0] k);
    logic [FFT_LN-1:0] r;
    r = '0;
    for (int b = 0; b < FFT_LN; b++) begin
      r[b] = k[FFT_LN-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: serial sample stream in, parallel frame plus start/done out to the FFT core.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready handshake on the sample side; fft_done level from the core.
interface fft_frame_loader_if;
  import fft_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [FFT_W-1:0]              in_real;
  logic [FFT_W-1:0]              in_imag;
  logic                          fft_start;
  logic [FFT_N-1:0][FFT_W-1:0]   fft_real;
  logic [FFT_N-1:0][FFT_W-1:0]   fft_imag;
  logic                          fft_done;
  logic [15:0]                   frames_issued;

  // Environment side: sample source plus FFT core.
  modport master (
    output in_valid, in_real, in_imag, fft_done,
    input  in_ready, fft_start, fft_real, fft_imag, frames_issued
  );

  // Loader side.
  modport slave (
    input  in_valid, in_real, in_imag, fft_done,
    output in_ready, fft_start, fft_real, fft_imag, frames_issued
  );

endinterface

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: one N-entry complex register array, single indexed write, full parallel read.
// Latency: write visible on rd_dat the cycle after we; clr zeroes the array the cycle after.
// Backpressure: none; the owner decides when writes are legal.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  clr,
  input  logic [FFT_LN-1:0]     idx,
  input  cplx_t                 wr_dat,
  output cplx_t [FFT_N-1:0]     rd_dat
);

  cplx_t [FFT_N-1:0] mem_q, mem_d;

  // Clear wins over write; the owner never does both to one bank in a cycle.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end else if (we) begin
      mem_d[idx] = wr_dat;
    end
  end

  // Sample storage, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_dat = mem_q;

endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: ping-pong assembly of N-sample frames, issued to the FFT core with a start pulse.
// Latency: 8th sample accepted at edge t -> fft_start and frame data registered at edge t+1.
// Backpressure: in_ready low while both banks hold frames; a bank frees on the core's done rising edge.
// FFT_LOADER_BITREV_EN: when defined, sample k lands in slot bitrev(k) instead of slot k.
module fft_frame_loader
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fft_frame_loader_if.slave bus
);

  localparam int N  = FFT_N;
  localparam int LN = FFT_LN;

  logic              fill_bank_q, fill_bank_d;
  logic [LN-1:0]     wr_idx_q, wr_idx_d;
  logic [1:0]        full_q, full_d;
  logic              fft_bank_q, fft_bank_d;
  logic              fft_busy_q, fft_busy_d;
  logic              done_q, done_d;
  logic              fft_start_q, fft_start_d;
  logic [15:0]       frames_issued_q, frames_issued_d;
  cplx_t [N-1:0]     out_q, out_d;

  cplx_t [N-1:0]     bank_rd [2];
  logic [1:0]        bank_we;
  logic [1:0]        bank_clr;
  cplx_t             wr_dat;
  logic [LN-1:0]     slot;
  logic              in_ready;
  logic              accept;
  logic              last_accept;
  logic              release_ev;
  logic              issue;
  logic              issue_bank;
  logic [N-1:0][FFT_W-1:0] real_o, imag_o;

  assign in_ready    = ~full_q[fill_bank_q];
  assign accept      = bus.in_valid & in_ready;
  assign last_accept = accept & (wr_idx_q == LN'(N - 1));
  // Only a done rising edge while a frame is out counts; a held level or a stray edge does nothing.
  assign release_ev  = bus.fft_done & ~done_q & fft_busy_q;
  // Busy and release are exclusive, so release and issue can never land on the same edge.
  assign issue       = ~fft_busy_q & (|full_q);
  // Banks fill alternately: with both full, the one fill_bank points back at is the older.
  assign issue_bank  = (&full_q) ? fill_bank_q : full_q[1];
  assign wr_dat      = '{re: bus.in_real, im: bus.in_imag};

`ifdef FFT_LOADER_BITREV_EN
  assign slot = bitrev(wr_idx_q);
`else
  assign slot = wr_idx_q;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b]  = accept & (fill_bank_q == 1'(b));
    // The released bank's contents already sit in the output register, so it is wiped on release.
    assign bank_clr[b] = release_ev & (fft_bank_q == 1'(b));

    fft_frame_bank u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (bank_we[b]),
      .clr    (bank_clr[b]),
      .idx    (slot),
      .wr_dat (wr_dat),
      .rd_dat (bank_rd[b])
    );
  end

  // Fill pointer, full flags, release and issue bookkeeping.
  always_comb begin
    fill_bank_d     = fill_bank_q;
    wr_idx_d        = wr_idx_q;
    full_d          = full_q;
    fft_bank_d      = fft_bank_q;
    fft_busy_d      = fft_busy_q;
    done_d          = bus.fft_done;
    fft_start_d     = 1'b0;
    frames_issued_d = frames_issued_q;
    out_d           = out_q;

    if (accept) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (last_accept) begin
        full_d[fill_bank_q] = 1'b1;
        fill_bank_d         = ~fill_bank_q;
      end
    end

    if (release_ev) begin
      fft_busy_d         = 1'b0;
      full_d[fft_bank_q] = 1'b0;
    end

    if (issue) begin
      fft_bank_d      = issue_bank;
      fft_busy_d      = 1'b1;
      fft_start_d     = 1'b1;
      frames_issued_d = frames_issued_q + 16'd1;
      out_d           = bank_rd[issue_bank];
    end
  end

  // Control and output registers; reset discards any partial or in-flight frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_bank_q     <= 1'b0;
      wr_idx_q        <= '0;
      full_q          <= '0;
      fft_bank_q      <= 1'b0;
      fft_busy_q      <= 1'b0;
      done_q          <= 1'b0;
      fft_start_q     <= 1'b0;
      frames_issued_q <= '0;
      out_q           <= '0;
    end else begin
      fill_bank_q     <= fill_bank_d;
      wr_idx_q        <= wr_idx_d;
      full_q          <= full_d;
      fft_bank_q      <= fft_bank_d;
      fft_busy_q      <= fft_busy_d;
      done_q          <= done_d;
      fft_start_q     <= fft_start_d;
      frames_issued_q <= frames_issued_d;
      out_q           <= out_d;
    end
  end

  // Unpack the held frame onto the core's parallel real/imag buses.
  always_comb begin
    real_o = '0;
    imag_o = '0;
    for (int i = 0; i < N; i++) begin
      real_o[i] = out_q[i].re;
      imag_o[i] = out_q[i].im;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.fft_start     = fft_start_q;
  assign bus.fft_real      = real_o;
  assign bus.fft_imag      = imag_o;
  assign bus.frames_issued = frames_issued_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: random and directed sample streams against a frame-level reference model.
// Expected frames are queued as the eighth sample of each frame is handed over; a monitor pops them on fft_start.
// A fake core answers each start with a done edge after a programmable delay and hold time.
module tb_fft_frame_loader;
  import fft_pkg::*;

  localparam int N  = FFT_N;
  localparam int W  = FFT_W;
  localparam int LN = FFT_LN;

  typedef struct {
    logic [N-1:0][W-1:0] re;
    logic [N-1:0][W-1:0] im;
    int                  acc_edge;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_loader_if bus ();

  fft_frame_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_t        exp_q[$];
  logic [W-1:0]  cur_re[$];
  logic [W-1:0]  cur_im[$];
  int            comp_edges[$];
  int            rel_edges[$];
  int            last_rel_edge = 0;
  int            rst_gen       = 0;
  int            exp_frames    = 0;
  int            core_delay    = 10;
  int            core_hold     = 1;
  int            core_cnt      = 0;
  int            hold_cnt      = 0;
  int            core_gen      = 0;

  // Frame slot that the k-th sample of a frame must occupy.
  function automatic int slot_of(input int k);
`ifdef FFT_LOADER_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < LN; b++) begin
      if ((k >> b) & 1) r = r + (1 << (LN - 1 - b));
    end
    return r;
`else
    return k;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Present one sample (called at a negedge) and hold it until the loader takes it.
  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
    int     waited;
    frame_t f;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_real  = re;
    bus.in_imag  = im;
    while (!bus.in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      fail_now("send_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    cur_re.push_back(re);
    cur_im.push_back(im);
    if (cur_re.size() == N) begin
      f.re = '0;
      f.im = '0;
      for (int k = 0; k < N; k++) begin
        f.re[slot_of(k)] = cur_re[k];
        f.im[slot_of(k)] = cur_im[k];
      end
      f.acc_edge = cyc + 1;
      exp_q.push_back(f);
      comp_edges.push_back(cyc + 1);
      cur_re.delete();
      cur_im.delete();
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Wait until every expected frame has issued and the fake core is quiet.
  task automatic drain();
    int waited;
    waited = 0;
    bus.in_valid = 1'b0;
    while ((exp_q.size() != 0 || core_cnt != 0 || hold_cnt != 0 || bus.fft_done) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2000) fail_now("drain_timeout");
    idle(2);
  endtask

  task automatic reset_checks();
    check("rst_fft_start", 128'(bus.fft_start), 128'(0));
    check("rst_frames_issued", 128'(bus.frames_issued), 128'(0));
    check("rst_fft_real", 128'(bus.fft_real), 128'(0));
    check("rst_fft_imag", 128'(bus.fft_imag), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  // Asynchronous reset mid-stream: model forgets partial frames, queued frames and releases.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rst_gen++;
    exp_q.delete();
    cur_re.delete();
    cur_im.delete();
    comp_edges.delete();
    rel_edges.delete();
    last_rel_edge = 0;
    exp_frames    = 0;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Fake FFT core: done rises core_delay cycles after start and stays high core_hold cycles.
  initial begin
    bus.fft_done = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) bus.fft_done = 1'b0;
      end
      if (bus.fft_start && !rst) begin
        core_cnt = core_delay;
        core_gen = rst_gen;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          if (bus.fft_done) begin
            // still high from the previous frame: drop first so the next rise is a real edge
            bus.fft_done = 1'b0;
            hold_cnt     = 0;
            core_cnt     = 1;
          end else begin
            bus.fft_done = 1'b1;
            hold_cnt     = core_hold;
            if (core_gen == rst_gen) begin
              rel_edges.push_back(cyc + 1);
              last_rel_edge = cyc + 1;
            end
          end
        end
      end
    end
  end

  // Monitor: in_ready against frames held, frame contents/count/timing on every start.
  initial begin
    int     held;
    int     exp_edge;
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 0;
        foreach (comp_edges[i]) if (comp_edges[i] <= cyc) held++;
        foreach (rel_edges[i])  if (rel_edges[i]  <= cyc) held--;
        check("in_ready", 128'(bus.in_ready), 128'(held < 2));
        if (bus.fft_start) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_fft_start");
          end else begin
            f = exp_q.pop_front();
            exp_frames++;
            exp_edge = (f.acc_edge + 1 > last_rel_edge + 1) ? f.acc_edge + 1 : last_rel_edge + 1;
            check("start_cycle", 128'(cyc), 128'(exp_edge));
            check("frame_real", 128'(bus.fft_real), 128'(f.re));
            check("frame_imag", 128'(bus.fft_imag), 128'(f.im));
            check("frames_issued", 128'(bus.frames_issued), 128'(exp_frames & 32'hFFFF));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0][W-1:0] tv;
    logic [N-1:0][W-1:0] ti;
    int tab[8];
    bus.in_valid = 1'b0;
    bus.in_real  = '0;
    bus.in_imag  = '0;

    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b0;
    @(negedge clk);

    // Natural-order frame 1..8 / -1..-8, core done 10 cycles after start.
    core_delay = 10;
    core_hold  = 1;
    for (int k = 1; k <= 8; k++) send(W'(k), W'(-k));
    drain();
    check("frames_after_first", 128'(bus.frames_issued), 128'(1));
`ifndef FFT_LOADER_BITREV_EN
    for (int i = 0; i < N; i++) begin
      tv[i] = W'(i + 1);
      ti[i] = W'(-(i + 1));
    end
    check("first_frame_real_const", 128'(bus.fft_real), 128'(tv));
    check("first_frame_imag_const", 128'(bus.fft_imag), 128'(ti));
`endif

    // Ramp 0..7: slot order fixed by the build.
    for (int k = 0; k < 8; k++) send(W'(k), W'(0));
    drain();
`ifdef FFT_LOADER_BITREV_EN
    tab = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    tab = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    for (int i = 0; i < N; i++) tv[i] = W'(tab[i]);
    check("ramp_slot_order", 128'(bus.fft_real), 128'(tv));
    check("frames_after_ramp", 128'(bus.frames_issued), 128'(2));

    // Backpressure: slow core, 24 back-to-back samples.
    core_delay = 50;
    core_hold  = 1;
    for (int k = 0; k < 24; k++) send(W'($urandom), W'($urandom));
    drain();

    // Level done held 20 cycles across a second and third frame.
    core_delay = 12;
    core_hold  = 20;
    for (int k = 0; k < 24; k++) send(W'($urandom), W'($urandom));
    drain();

    // Done rising edge lands on the 8th accept of the following frame.
    core_delay = 6;
    core_hold  = 1;
    for (int k = 0; k < 16; k++) send(W'($urandom), W'($urandom));
    drain();

    // Reset after 5 samples, then a fresh frame.
    core_delay = 10;
    for (int k = 0; k < 5; k++) send(W'(16'hAA00 + k), W'(16'h5500 + k));
    do_reset();
    check("rst_midframe_count", 128'(bus.frames_issued), 128'(0));
    for (int k = 0; k < 8; k++) send(W'(16'h0100 + k), W'(16'h0200 + k));
    drain();
    check("fresh_frame_count", 128'(bus.frames_issued), 128'(1));

    // Reset while the core is working: its late done must be ignored.
    core_delay = 15;
    for (int k = 0; k < 8; k++) send(W'($urandom), W'($urandom));
    begin
      int waited;
      waited = 0;
      while (!bus.fft_start && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.fft_start) fail_now("midfft_start_timeout");
    end
    idle(3);
    do_reset();
    drain();
    check("stale_done_count", 128'(bus.frames_issued), 128'(0));
    core_delay = 5;
    for (int k = 0; k < 8; k++) send(W'($urandom), W'($urandom));
    drain();
    check("after_midfft_reset_count", 128'(bus.frames_issued), 128'(1));

    // Random traffic: random gaps and core response times.
    for (int fr = 0; fr < 30; fr++) begin
      core_delay = $urandom_range(1, 20);
      core_hold  = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(W'($urandom), W'($urandom));
      end
    end
    drain();
    check("random_frames_count", 128'(bus.frames_issued), 128'(31));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
